// File: rtl/audio_pkg.sv
// Shared audio types: note codes, table field widths and sequencer state encoding.
package audio_pkg;

    localparam int NOTE_W = 4;
    localparam int LEN_W  = 4;
    localparam int SEL_W  = 4;

    typedef enum logic [NOTE_W-1:0] {
        do_, do_s, re, re_s, mi, fa, fa_s, sol,
        sol_s, la, la_s, si, do_H, do_sH, re_H, silence
    } musicNote;

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} seq_state_t;

    typedef enum logic [1:0] {IDX_HOLD, IDX_ZERO, IDX_INC} idx_op_t;

endpackage

// File: rtl/beat_timer.sv
// Beat prescaler: one-cycle beatTick every BEAT_CYCLES enabled cycles; clear restarts the count.
module beat_timer #(
    parameter int BEAT_CYCLES = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic beatTick
);

    localparam int CW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEAT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign beatTick = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/melody_sequencer.sv
// Walks the note table, holding each note for note_length beats with a silent gap between notes.
// Define MELODY_LOOP_EN to restart from index 0 at melody end instead of stopping.
module melody_sequencer
    import audio_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BEAT_CYCLES = CLK_FREQ_HZ / 4,
    parameter int GAP_CYCLES  = CLK_FREQ_HZ / 80,
    parameter int MAX_NOTES   = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         startMelody,
    input  logic                         stopMelody,
    input  logic [SEL_W-1:0]             melodySelectIn,
    output logic [SEL_W-1:0]             melodySelect,
    output logic [$clog2(MAX_NOTES)-1:0] noteIndex,
    input  logic [NOTE_W-1:0]            tone,
    input  logic [LEN_W-1:0]             note_length,
    input  logic                         silenceOutN,
    output logic [NOTE_W-1:0]            toneOut,
    output logic                         enableSound,
    output logic                         busy,
    output logic                         melodyDone
);

    localparam int IW = $clog2(MAX_NOTES);
    localparam logic [IW-1:0] IDX_LAST = IW'(MAX_NOTES - 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    seq_state_t       state, state_n;
    idx_op_t          idx_op;
    logic             latch_sel, load_note, done_set, advance, end_melody;
    logic             sil_q, beat_tick;
    logic [LEN_W-1:0] beats_left;
    logic [GW-1:0]    gap_cnt;

    beat_timer #(.BEAT_CYCLES(BEAT_CYCLES)) u_beat_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (state != PLAY),
        .enable   (state == PLAY),
        .beatTick (beat_tick)
    );

    always_comb begin
        state_n    = state;
        idx_op     = IDX_HOLD;
        latch_sel  = 1'b0;
        load_note  = 1'b0;
        done_set   = 1'b0;
        advance    = 1'b0;
        end_melody = 1'b0;
        case (state)
            IDLE: if (startMelody && !stopMelody) begin
                state_n   = LOAD;
                idx_op    = IDX_ZERO;
                latch_sel = 1'b1;
            end
            LOAD: if (note_length == '0) begin
                end_melody = 1'b1;
            end else begin
                load_note = 1'b1;
                state_n   = PLAY;
            end
            PLAY: if (beat_tick && beats_left == LEN_W'(1)) begin
                if (GAP_CYCLES > 0) state_n = GAP;
                else                advance = 1'b1;
            end
            GAP:  if (gap_cnt == GAP_LAST) advance = 1'b1;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (advance) begin
            if (noteIndex == IDX_LAST) begin
                end_melody = 1'b1;
            end else begin
                idx_op  = IDX_INC;
                state_n = LOAD;
            end
        end
        if (end_melody) begin
            done_set = 1'b1;
            idx_op   = IDX_ZERO;
`ifdef MELODY_LOOP_EN
            state_n  = LOAD;
`else
            state_n  = DONE;
`endif
        end
        // Abort overrides everything, including a melody end in the same cycle.
        if (stopMelody && state != IDLE) begin
            state_n   = IDLE;
            idx_op    = IDX_ZERO;
            done_set  = 1'b0;
            load_note = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            melodySelect <= '0;
            noteIndex    <= '0;
            toneOut      <= '0;
            sil_q        <= 1'b0;
            beats_left   <= '0;
            gap_cnt      <= '0;
            melodyDone   <= 1'b0;
        end else begin
            state      <= state_n;
            melodyDone <= done_set;
            if (latch_sel) melodySelect <= melodySelectIn;
            case (idx_op)
                IDX_ZERO: noteIndex <= '0;
                IDX_INC:  noteIndex <= noteIndex + IW'(1);
                default:  noteIndex <= noteIndex;
            endcase
            if (load_note) begin
                toneOut    <= tone;
                sil_q      <= silenceOutN;
                beats_left <= note_length;
            end else if (state == PLAY && beat_tick) begin
                beats_left <= beats_left - LEN_W'(1);
            end
            gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;
        end
    end

    assign enableSound = (state == PLAY) && sil_q;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with a stub note table (BEAT_CYCLES=4, GAP_CYCLES=2).
module tb_melody_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       startMelody, stopMelody;
    logic [3:0] melodySelectIn, melodySelect;
    logic [4:0] noteIndex;
    logic [3:0] tone, note_length, toneOut;
    logic       silenceOutN, enableSound, busy, melodyDone;

    logic [3:0] tb_tone [32];
    logic [3:0] tb_len  [32];
    logic       tb_sil  [32];

    logic       cap_busy [320];
    logic       cap_en   [320];
    logic       cap_done [320];
    logic [3:0] cap_tone [320];
    logic [4:0] cap_idx  [320];

    int total = 0;
    int bad   = 0;
    int cnt_a, cnt_b, cnt_c, cnt_d;

    always #5 clk = ~clk;

    assign tone        = tb_tone[noteIndex];
    assign note_length = tb_len[noteIndex];
    assign silenceOutN = tb_sil[noteIndex];

    melody_sequencer #(.BEAT_CYCLES(4), .GAP_CYCLES(2), .MAX_NOTES(32)) dut (
        .clk(clk), .reset(reset), .startMelody(startMelody), .stopMelody(stopMelody),
        .melodySelectIn(melodySelectIn), .melodySelect(melodySelect), .noteIndex(noteIndex),
        .tone(tone), .note_length(note_length), .silenceOutN(silenceOutN), .toneOut(toneOut),
        .enableSound(enableSound), .busy(busy), .melodyDone(melodyDone)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_table();
        for (int i = 0; i < 32; i++) begin
            tb_tone[i] = 4'h0;
            tb_len[i]  = 4'h0;
            tb_sil[i]  = 1'b1;
        end
    endtask

    // sol/2, mi/2, end
    task automatic table_two_notes();
        clear_table();
        tb_tone[0] = 4'd7; tb_len[0] = 4'd2;
        tb_tone[1] = 4'd4; tb_len[1] = 4'd2;
    endtask

    task automatic start_pulse(input logic [3:0] sel);
        melodySelectIn = sel;
        startMelody    = 1'b1;
        tick();
        startMelody    = 1'b0;
    endtask

    task automatic stop_pulse();
        stopMelody = 1'b1;
        tick();
        stopMelody = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            cap_busy[i] = busy;
            cap_en[i]   = enableSound;
            cap_done[i] = melodyDone;
            cap_tone[i] = toneOut;
            cap_idx[i]  = noteIndex;
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; startMelody = 1'b0; stopMelody = 1'b0; melodySelectIn = 4'h0;
        clear_table();
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_en", enableSound, 0);
        chk("rst_done", melodyDone, 0);
        chk("rst_tone", toneOut, 0);
        chk("rst_idx", noteIndex, 0);
        chk("rst_sel", melodySelect, 0);
        reset = 1'b0;
        tick();

`ifndef MELODY_LOOP_EN
        // Two-note melody: LOAD, 8 PLAY, 2 GAP, LOAD, 8 PLAY, 2 GAP, LOAD(len0), DONE
        table_two_notes();
        start_pulse(4'd5);
        melodySelectIn = 4'd9;
        capture(40);
        cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
        for (int i = 0; i < 40; i++) begin
            if (cap_busy[i]) cnt_a++;
            if (cap_done[i]) cnt_b++;
            if (cap_en[i] && cap_tone[i] == 4'd7) cnt_c++;
            if (cap_en[i] && cap_tone[i] == 4'd4) cnt_d++;
        end
        chk("t1_busy_cycles", cnt_a, 24);
        chk("t1_done_count", cnt_b, 1);
        chk("t1_sol_cycles", cnt_c, 8);
        chk("t1_mi_cycles", cnt_d, 8);
        chk("t1_first_play_en", cap_en[1], 1);
        chk("t1_first_play_tone", cap_tone[1], 7);
        chk("t1_gap_en", cap_en[9], 0);
        chk("t1_gap_tone_held", cap_tone[10], 7);
        chk("t1_second_tone", cap_tone[12], 4);
        chk("t1_done_pos", cap_done[23], 1);
        chk("t1_busy_after_done", cap_busy[24], 0);
        chk("t1_sel_latched", melodySelect, 5);

        // Rest note: silent for 12 PLAY cycles with toneOut=F
        clear_table();
        tb_tone[0] = 4'hF; tb_len[0] = 4'd3; tb_sil[0] = 1'b0;
        start_pulse(4'd1);
        capture(24);
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int i = 0; i < 24; i++) begin
            if (cap_en[i])   cnt_a++;
            if (cap_done[i]) cnt_b++;
            if (cap_busy[i]) cnt_c++;
        end
        chk("t2_en_cycles", cnt_a, 0);
        chk("t2_done_count", cnt_b, 1);
        chk("t2_busy_cycles", cnt_c, 17);
        chk("t2_tone_first", cap_tone[1], 4'hF);
        chk("t2_tone_last", cap_tone[12], 4'hF);
        chk("t2_done_pos", cap_done[16], 1);

        // 32 single-beat notes: 7 cycles each, DONE at cycle 224
        clear_table();
        for (int i = 0; i < 32; i++) begin
            tb_tone[i] = 4'(i);
            tb_len[i]  = 4'd1;
        end
        start_pulse(4'd2);
        capture(240);
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int i = 0; i < 240; i++) begin
            if (cap_done[i]) cnt_b++;
            if (cap_idx[i] > cnt_a) cnt_a = cap_idx[i];
        end
        for (int i = 7; i < 224; i++) if (cap_idx[i] == 5'd0) cnt_c++;
        chk("t4_max_idx", cnt_a, 31);
        chk("t4_done_count", cnt_b, 1);
        chk("t4_zero_mid_run", cnt_c, 0);
        chk("t4_idx_last_load", cap_idx[217], 31);
        chk("t4_done_pos", cap_done[224], 1);
        chk("t4_idx_at_done", cap_idx[224], 0);
        chk("t4_idle_after", cap_busy[225], 0);

        // Start while busy is ignored; original timeline and selection stand
        table_two_notes();
        start_pulse(4'd3);
        for (int i = 0; i < 5; i++) tick();
        start_pulse(4'd8);
        capture(20);
        chk("t6_sel_kept", melodySelect, 3);
        chk("t6_done_pos", cap_done[17], 1);
        chk("t6_idle_after", cap_busy[18], 0);
`else
        // Looping: a pass is 23 cycles, melodyDone in the LOAD cycle where noteIndex returns to 0
        table_two_notes();
        start_pulse(4'd6);
        capture(80);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 80; i++) begin
            if (cap_done[i]) cnt_a++;
            if (cap_busy[i]) cnt_b++;
        end
        chk("loop_done_count", cnt_a, 3);
        chk("loop_busy_cycles", cnt_b, 80);
        chk("loop_done_pos", cap_done[23], 1);
        chk("loop_idx_at_done", cap_idx[23], 0);
        chk("loop_replay_tone", cap_tone[24], 7);
        chk("loop_replay_en", cap_en[24], 1);
        stop_pulse();
        chk("loop_stop_busy", busy, 0);
`endif

        // Stop 5 cycles into the second note
        table_two_notes();
        start_pulse(4'd4);
        for (int i = 0; i < 17; i++) tick();
        chk("t3_pre_en", enableSound, 1);
        chk("t3_pre_idx", noteIndex, 1);
        stop_pulse();
        chk("t3_en", enableSound, 0);
        chk("t3_busy", busy, 0);
        chk("t3_idx", noteIndex, 0);
        chk("t3_done", melodyDone, 0);
        capture(30);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 30; i++) begin
            if (cap_done[i]) cnt_a++;
            if (cap_busy[i]) cnt_b++;
        end
        chk("t3_no_done_after", cnt_a, 0);
        chk("t3_stay_idle", cnt_b, 0);
        start_pulse(4'd4);
        capture(30);
        chk("t3_restart_idx", cap_idx[1], 0);
        chk("t3_restart_tone", cap_tone[1], 7);
        chk("t3_restart_en", cap_en[1], 1);
        chk("t3_restart_done", cap_done[23], 1);
        stop_pulse();

        // Start and stop together from IDLE
        melodySelectIn = 4'd7;
        startMelody = 1'b1; stopMelody = 1'b1;
        tick();
        startMelody = 1'b0; stopMelody = 1'b0;
        chk("t5_busy", busy, 0);
        tick(); tick();
        chk("t5_busy_later", busy, 0);
        chk("t5_sel_unlatched", melodySelect, 4);

        // Asynchronous reset mid-PLAY, between clock edges
        table_two_notes();
        start_pulse(4'd5);
        tick(); tick(); tick();
        chk("t7_pre_en", enableSound, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t7_en", enableSound, 0);
        chk("t7_busy", busy, 0);
        chk("t7_tone", toneOut, 0);
        chk("t7_sel", melodySelect, 0);
        chk("t7_idx", noteIndex, 0);
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        chk("t7_idle_after", busy, 0);
        chk("t7_quiet_after", enableSound, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
